// File: rtl/swerv_types.sv
// Shared types for the multiply scheduler.
//   MUL_LATENCY     : number of multiplier stages (E1..E3) between grant and writeback
//   mul_pkt_t       : control packet issued to the multiplier with each operation
//   mul_sched_pkt_t : request packet from an issue pipe (sign/low controls, rd tag, operands)
package swerv_types;

    localparam int MUL_LATENCY = 3;

    typedef struct packed {
        logic valid;
        logic rs1_sign;
        logic rs2_sign;
        logic low;
        logic load_mul_rs1_bypass_e1;
        logic load_mul_rs2_bypass_e1;
    } mul_pkt_t;

    typedef struct packed {
        logic        rs1_sign;
        logic        rs2_sign;
        logic        low;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } mul_sched_pkt_t;

endpackage

// File: rtl/exu_mul_rr_arb.sv
// Two-requester arbiter for the shared multiplier.
// Ports:
//   clk, rst_l : clock and asynchronous active-low reset
//   en_i       : grant enable; no grant is issued while low
//   req_i[1:0] : request from pipe 1 / pipe 0
//   gnt_o[1:0] : one-hot (or zero) grant, combinational
// Build option RV_MUL_RR_ARB_EN: defined -> round-robin on contention,
// undefined -> fixed priority with pipe 0 ahead of pipe 1 (stateless).
module exu_mul_rr_arb (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef RV_MUL_RR_ARB_EN
    // Last-winner flop, stored as "pipe 1 is favoured on the next contention".
    // Its reset value of 0 therefore gives pipe 0 the first contended grant.
    logic prio1_q;
    logic prio1_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = prio1_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Every grant, contended or not, hands priority to the other pipe.
    always_comb begin
        prio1_d = prio1_q;
        if (|gnt_o) begin
            prio1_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            prio1_q <= 1'b0;
        end else begin
            prio1_q <= prio1_d;
        end
    end
`else
    // Fixed priority needs no state; clock and reset are kept on the port list
    // so both builds share one instantiation.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_l;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
        end
    end
`endif

endmodule

// File: rtl/exu_mul_sched.sv
// Multiply scheduler: arbitrates two issue pipes onto one fully pipelined
// 3-stage multiplier and tracks the destination tag of each op through E1..E3.
// Ports:
//   clk, rst_l               : clock, asynchronous active-low reset
//   req0/1_valid, req0/1_pkt : requests from pipe 0 / pipe 1
//   gnt0, gnt1               : request accepted this cycle (combinational)
//   freeze                   : pipeline freeze, holds every stage and blocks grants
//   flush_e2                 : kills ops in E1/E2 and any same-cycle grant
//   mp, mul_a, mul_b         : multiplier issue packet and operands
//   res_valid/src/rd         : E3 writeback tag
//   inflight_cnt             : number of valid ops in E1..E3
// Build option RV_MUL_RR_ARB_EN selects round-robin arbitration (see exu_mul_rr_arb).
module exu_mul_sched
    import swerv_types::*;
(
    input  logic           clk,
    input  logic           rst_l,
    input  logic           req0_valid,
    input  logic           req1_valid,
    input  mul_sched_pkt_t req0_pkt,
    input  mul_sched_pkt_t req1_pkt,
    output logic           gnt0,
    output logic           gnt1,
    input  logic           freeze,
    input  logic           flush_e2,
    output mul_pkt_t       mp,
    output logic [31:0]    mul_a,
    output logic [31:0]    mul_b,
    output logic           res_valid,
    output logic           res_src,
    output logic [4:0]     res_rd,
    output logic [1:0]     inflight_cnt
);

    localparam int E3 = MUL_LATENCY - 1;

    logic [1:0]     gnt_vec;
    logic           any_gnt;
    logic           arb_en;
    mul_sched_pkt_t win_pkt;

    // Index 0 is E1, index E3 is the writeback stage.
    logic [MUL_LATENCY-1:0]      vld_q, vld_d;
    logic [MUL_LATENCY-1:0]      src_q, src_d;
    logic [MUL_LATENCY-1:0][4:0] rd_q,  rd_d;

    // Reset is folded in so grants read 0 while reset is held.
    assign arb_en = rst_l & ~freeze & ~flush_e2;

    exu_mul_rr_arb u_arb (
        .clk   (clk),
        .rst_l (rst_l),
        .en_i  (arb_en),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt_vec)
    );

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign any_gnt = |gnt_vec;

    // Zero packet when nothing is granted, so the issue fields are quiet.
    assign win_pkt = gnt_vec[1] ? req1_pkt : (gnt_vec[0] ? req0_pkt : '0);

    always_comb begin
        mp          = '0;
        mp.valid    = any_gnt;
        mp.rs1_sign = win_pkt.rs1_sign;
        mp.rs2_sign = win_pkt.rs2_sign;
        mp.low      = win_pkt.low;
    end

    assign mul_a = win_pkt.a;
    assign mul_b = win_pkt.b;

    // Flush is applied after the (optional) shift: an E2 op that moves into E3
    // on a flush cycle survives, and under freeze+flush E3 is simply kept.
    always_comb begin
        vld_d = vld_q;
        src_d = src_q;
        rd_d  = rd_q;
        if (!freeze) begin
            vld_d = {vld_q[E3-1:0], any_gnt};
            src_d = {src_q[E3-1:0], gnt_vec[1]};
            rd_d  = {rd_q[E3-1:0],  win_pkt.rd};
        end
        if (flush_e2) begin
            vld_d[E3-1:0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_q <= '0;
            src_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            src_q <= src_d;
            rd_q  <= rd_d;
        end
    end

    assign res_valid    = vld_q[E3] & ~freeze;
    assign res_src      = src_q[E3];
    assign res_rd       = rd_q[E3];
    assign inflight_cnt = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};

endmodule

// File: doc/exu_mul_sched.md
EXU_MUL_SCHED -- requirements
Module: exu_mul_sched

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all flops on clk.
REQ-002 SHALL have port rst_l, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports req0_valid/req1_valid, input, 1 each, multiply request from pipe 0/pipe 1.
REQ-004 SHALL have ports req0_pkt/req1_pkt, input, mul_sched_pkt_t: rs1_sign, rs2_sign, low, rd[4:0], a[31:0], b[31:0].
REQ-005 SHALL have ports gnt0/gnt1, output, 1 each, request accepted this cycle.
REQ-006 SHALL have port freeze, input, 1, pipeline freeze.
REQ-007 SHALL have port flush_e2, input, 1, kill E1/E2 in-flight ops and same-cycle grants.
REQ-008 SHALL have ports mp (output, mul_pkt_t), mul_a/mul_b (output, 32 each): multiplier issue.
REQ-009 SHALL have ports res_valid (output, 1), res_src (output, 1), res_rd (output, 5): E3 writeback tag.
REQ-010 SHALL have port inflight_cnt, output, 2, number of valid ops in E1..E3.

Function
REQ-011 SHALL assert gnt0/gnt1 combinationally, one-hot or zero, only when ~freeze & ~flush_e2.
REQ-012 SHALL grant the sole valid requester when only one is valid.
REQ-013 SHALL, when both are valid, grant by the arbitration policy (REQ-024/025); loser holds its request.
REQ-014 SHALL drive mp.valid=gnt0|gnt1; mp sign/low fields and mul_a/mul_b from the winner; zero when no grant; load-bypass fields always 0.
REQ-015 SHALL track in-flight ops in 3-stage shift register {vld,src,rd} for E1,E2,E3; shift only when ~freeze.
REQ-016 SHALL load E1 with {1,winner id,winner rd} on grant, else vld_e1=0.
REQ-017 SHALL hold all stages unchanged while freeze=1 (no grant, no shift).
REQ-018 SHALL, on flush_e2, clear vld of E1 and E2 (post-shift) and suppress grant; E3 op still writes back.
REQ-019 SHALL give flush_e2 priority over freeze when both asserted: clear E1/E2, do not shift, keep E3.
REQ-020 SHALL drive res_valid=vld_e3 & ~freeze, res_src/res_rd=E3 tag; result latency exactly 3 unfrozen cycles after grant.
REQ-021 SHALL drive inflight_cnt = vld_e1+vld_e2+vld_e3 (max 3, no wrap).
REQ-022 SHALL accept back-to-back grants every unfrozen cycle (multiplier fully pipelined; no stall).

Reset
REQ-023 SHALL on rst_l=0 clear all vld bits, tags, and last-winner flop to 0; gnt0/gnt1, mp.valid, res_valid, inflight_cnt read 0; reset mid-operation discards in-flight ops with no writeback.

Configuration
REQ-024 SHALL, with RV_MUL_RR_ARB_EN defined, round-robin on contention: grant the pipe not granted last; last-winner flop updates on every grant.
REQ-025 SHALL, without RV_MUL_RR_ARB_EN, use fixed priority pipe 0 over pipe 1; no last-winner flop.

Structure
REQ-026 SHALL place mul_sched_pkt_t and MUL_LATENCY=3 in swerv_types; reuse existing mul_pkt_t.
REQ-027 SHALL implement arbitration in sub-module exu_mul_rr_arb (2 requesters, one-hot grant, enable input).

Verification
REQ-028 Single: req0 rd=5, a=7, b=6, low=1 -> gnt0 cycle 0, mp.valid, mul_a=7; res_valid, res_src=0, res_rd=5 at cycle 3.
REQ-029 Contention (RR build): both valid 4 cycles -> grants 0,1,0,1; res_src 0,1,0,1 cycles 3-6; inflight_cnt peaks 3.
REQ-030 Contention (fixed build): both valid 3 cycles -> gnt0 each cycle, gnt1 never.
REQ-031 Freeze: grant cycle 0, freeze cycles 1-2 -> no grants, res_valid at cycle 5, E tags unchanged while frozen.
REQ-032 Flush: grants cycles 0,1,2, flush_e2 cycle 2 -> cycle-2 grant suppressed, only cycle-0 op writes back (cycle 3), inflight_cnt=0 by cycle 4.
REQ-033 Reset mid-flight: 2 ops in flight, rst_l low 1 cycle -> no res_valid afterwards, inflight_cnt=0.
